reg_write_demux16: RTL and testbench

Write-side counterpart of the 16:1 register read multiplexer. It takes one write stream (address + data, valid/ready handshake) and routes each accepted word into one of sixteen WIDTH-bit holding registers. All sixteen registers are exposed in parallel as out0..out15 for the read-side mux. A sequential bulk-clear engine zeroes the bank one register per cycle, and a per-register "written" mask is kept.

---
 rtl/reg_write_demux16_pkg.sv | 13 +
 rtl/reg_write_demux16_dec4_16.sv | 18 +
 rtl/reg_write_demux16.sv | 131 +++++++++++++
 tb/tb_reg_write_demux16.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_demux16_pkg.sv
// Shared types and constants for the sixteen-entry write demultiplexer
// and its one-hot write-enable decoder.
package reg_write_demux16_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_write_demux16_dec4_16.sv
// 4-to-16 one-hot decoder with enable. It produces the per-register write
// strobes for either the write port address or the clear counter.
module dec4_16
  import reg_write_demux16_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   sel,
  output logic [NUM_REGS-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign onehot[gi] = en && (sel == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_write_demux16.sv
// Routes a valid/ready write stream into sixteen holding registers, with a
// one-register-per-cycle bulk clear engine and a per-entry written mask.
module reg_write_demux16
  import reg_write_demux16_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output logic [15:0]      written
);

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]      bank_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   written_reg;

  logic                  clearing;
  logic                  wr_accept;
  logic                  dec_en;
  logic [ADDR_W-1:0]     dec_sel;
  logic [NUM_REGS-1:0]   reg_we;

  // A pending clear request blocks the write port on the same edge.
  assign clearing  = (state_reg == ST_CLEAR);
  assign wr_ready  = (state_reg == ST_IDLE) && !clr_req && !rst;
  assign wr_accept = wr_valid && wr_ready;
  assign clr_busy  = clearing;

  assign dec_sel = clearing ? cnt_reg : wr_addr;
  assign dec_en  = clearing || wr_accept;

  dec4_16 u_dec (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (reg_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to zero on the final step, ready for the next run.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(NUM_REGS - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_reg[i] <= CLR_VALUE;
      end
      written_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) begin
          bank_reg[i]    <= clearing ? CLR_VALUE : wr_data;
          written_reg[i] <= !clearing;
        end
      end
    end
  end

  assign written = written_reg;

  assign out0  = bank_reg[0];
  assign out1  = bank_reg[1];
  assign out2  = bank_reg[2];
  assign out3  = bank_reg[3];
  assign out4  = bank_reg[4];
  assign out5  = bank_reg[5];
  assign out6  = bank_reg[6];
  assign out7  = bank_reg[7];
  assign out8  = bank_reg[8];
  assign out9  = bank_reg[9];
  assign out10 = bank_reg[10];
  assign out11 = bank_reg[11];
  assign out12 = bank_reg[12];
  assign out13 = bank_reg[13];
  assign out14 = bank_reg[14];
  assign out15 = bank_reg[15];

endmodule

// File: tb/tb_reg_write_demux16.sv
// Directed bench for reg_write_demux16: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_reg_write_demux16;

  localparam int SIG_WRITTEN = 16;
  localparam int SIG_READY   = 17;
  localparam int SIG_BUSY    = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic [31:0] o [16];
  logic [15:0] written;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  reg_write_demux16 #(.WIDTH(32), .CLR_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .out0(o[0]),   .out1(o[1]),   .out2(o[2]),   .out3(o[3]),
    .out4(o[4]),   .out5(o[5]),   .out6(o[6]),   .out7(o[7]),
    .out8(o[8]),   .out9(o[9]),   .out10(o[10]), .out11(o[11]),
    .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
    .written(written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int id);
    if (id < 16)            return o[id];
    if (id == SIG_WRITTEN)  return {16'h0, written};
    if (id == SIG_READY)    return {31'h0, wr_ready};
    return {31'h0, clr_busy};
  endfunction

  // Monitor: everything due in the current cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = sb.pop_front();
      got = get_sig(e.id);
      checks++;
      if (got === e.exp) begin
        passed++;
        $display("check %-14s cyc=%0d got=%h", e.name, cyc, got);
      end else begin
        $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, got, e.exp);
      end
    end
  end

  task automatic expect_sig(input int id, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cyc; e.id = id; e.exp = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [3:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    // Reset held: wr_ready must be low, bank at clear value.
    tick(); tick();
    expect_sig(SIG_READY, 32'h0, "ready_in_rst");
    expect_sig(0, 32'h0, "out0_rst");
    expect_sig(15, 32'h0, "out15_rst");
    tick();
    rst = 1'b0;
    tick();
    expect_sig(SIG_READY, 32'h1, "ready_idle");
    expect_sig(SIG_BUSY, 32'h0, "busy_idle");
    expect_sig(SIG_WRITTEN, 32'h0, "written_rst");
    for (int i = 0; i < 16; i++) expect_sig(i, 32'h0, "outN_rst");

    // Single write, no combinational bypass.
    wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
    expect_sig(5, 32'h0, "out5_nobypass");
    tick();
    wr_valid = 1'b0;
    expect_sig(5, 32'hDEADBEEF, "out5_write");
    expect_sig(SIG_WRITTEN, 32'h0020, "written_5");
    expect_sig(4, 32'h0, "out4_untouched");
    expect_sig(6, 32'h0, "out6_untouched");

    // Back-to-back; bit 5 still set from the previous write.
    write1(4'd3, 32'h11);
    expect_sig(3, 32'h11, "out3_first");
    write1(4'd3, 32'h22);
    write1(4'd15, 32'hFFFFFFFF);
    expect_sig(3, 32'h22, "out3_last_wins");
    expect_sig(15, 32'hFFFFFFFF, "out15_b2b");
    expect_sig(SIG_WRITTEN, 32'h8028, "written_b2b");

    // Fill with 0x100+i so that every cleared entry is distinguishable.
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i); wr_data = 32'h100 + i; wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    expect_sig(SIG_WRITTEN, 32'hFFFF, "written_full");
    clr_req = 1'b1;
    expect_sig(SIG_READY, 32'h0, "ready_clrreq");
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_sig(SIG_BUSY, 32'h1, "busy_clear");
      expect_sig(SIG_READY, 32'h0, "ready_clear");
      expect_sig(k, 32'h100 + k, "not_yet_clr");
      if (k > 0) expect_sig(k - 1, 32'h0, "just_cleared");
      expect_sig(15, (k < 16) ? 32'h10F : 32'h0, "out15_holds");
      tick();
    end
    expect_sig(SIG_BUSY, 32'h0, "busy_done");
    expect_sig(SIG_READY, 32'h1, "ready_done");
    expect_sig(SIG_WRITTEN, 32'h0, "written_clr");
    expect_sig(15, 32'h0, "out15_clr");
    expect_sig(7, 32'h0, "out7_clr");

    // Clear request beats a simultaneous write; the writer holds on.
    write1(4'd2, 32'h55);
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'hAA;
    expect_sig(SIG_READY, 32'h0, "prio_ready");
    tick();
    clr_req = 1'b0;
    tick(); tick();
    expect_sig(2, 32'h55, "prio_out2_old");
    expect_sig(SIG_READY, 32'h0, "prio_refused");
    for (int k = 3; k < 16; k++) tick();
    expect_sig(2, 32'h0, "prio_out2_clr");
    expect_sig(SIG_BUSY, 32'h1, "prio_busy_last");
    tick();
    expect_sig(SIG_BUSY, 32'h0, "prio_busy_end");
    expect_sig(SIG_READY, 32'h1, "prio_ready_back");
    tick();
    wr_valid = 1'b0;
    expect_sig(2, 32'hAA, "prio_out2_late");
    expect_sig(SIG_WRITTEN, 32'h0004, "prio_written");

    // Reset at clear cycle 7 abandons the sequence.
    write1(4'd12, 32'hCC);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    expect_sig(12, 32'hCC, "pre_rst_out12");
    expect_sig(SIG_BUSY, 32'h1, "pre_rst_busy");
    tick();
    rst = 1'b1;
    #1;
    expect_sig(12, 32'h0, "rst_out12");
    expect_sig(2, 32'h0, "rst_out2");
    expect_sig(SIG_BUSY, 32'h0, "rst_busy");
    expect_sig(SIG_READY, 32'h0, "rst_ready");
    expect_sig(SIG_WRITTEN, 32'h0, "rst_written");
    tick();
    rst = 1'b0;
    tick();
    expect_sig(SIG_BUSY, 32'h0, "post_rst_busy");
    expect_sig(SIG_READY, 32'h1, "post_rst_ready");
    wr_addr = 4'd9; wr_data = 32'h99; wr_valid = 1'b1;
    expect_sig(9, 32'h0, "out9_nobypass");
    tick();
    wr_valid = 1'b0;
    expect_sig(9, 32'h99, "out9_write");
    expect_sig(SIG_WRITTEN, 32'h0200, "written_9");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain got=%0d pending expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
